// File: rtl/calc_sequencer_if.sv
// Command and queue-side signal bundle for calc_sequencer.
// The master side is the command source plus the operand queue. The slave side is the sequencer.
interface calc_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [7:0]  in_data;
    logic [1:0]  q_opcode;
    logic [7:0]  q_back;
    logic [15:0] q_top_conc;
    logic        q_is_err;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        err;
    logic [2:0]  count;

    modport master (
        output in_valid, in_kind, in_data, q_top_conc, q_is_err,
        input  in_ready, q_opcode, q_back, res_valid, res_data, err, count
    );

    modport slave (
        input  in_valid, in_kind, in_data, q_top_conc, q_is_err,
        output in_ready, q_opcode, q_back, res_valid, res_data, err, count
    );
endinterface

// File: rtl/calc_sequencer.sv
// Command sequencer feeding the 5-entry operand queue. It performs ALU/shift-add MUL work on the
// queue's front pair, issues single-cycle queue strobes, and mirrors occupancy to reject illegal commands.
module calc_sequencer #(
    parameter int QDEPTH     = 5,
    parameter int MUL_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    calc_sequencer_if.slave   bus
);
    localparam int         IW       = $clog2(MUL_CYCLES + 1);
    localparam logic [2:0] QDEPTH_C = 3'(QDEPTH);
    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_NOP   = 2'b01;
    localparam logic [1:0] OP_RED   = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ISSUE, S_ERR} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      back_q, back_d;
    logic            res_valid_q, res_valid_d;
    logic [7:0]      res_data_q, res_data_d;
    logic            err_q, err_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      mul_a_q, mul_a_d;
    logic [7:0]      mul_b_q, mul_b_d;
    logic [7:0]      acc_q, acc_d;
    logic [IW-1:0]   iter_q, iter_d;

    logic [7:0] opa, opb, alu_res, acc_step;
    logic       fail;

    assign opa = bus.q_top_conc[7:0];
    assign opb = bus.q_top_conc[15:8];

    always_comb begin
        alu_res = 8'h00;
        case (bus.in_data[2:0])
            3'd0:    alu_res = opa + opb;
            3'd1:    alu_res = opa - opb;
            3'd2:    alu_res = opa & opb;
            3'd3:    alu_res = opa | opb;
            3'd4:    alu_res = opa ^ opb;
            default: alu_res = 8'h00;
        endcase
    end

    assign acc_step = mul_b_q[0] ? (acc_q + mul_a_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        back_d      = back_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        err_d       = err_q;
        count_d     = count_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        iter_d      = iter_q;
        fail        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !err_q) begin
                    if (!bus.in_kind) begin
                        if (count_q < QDEPTH_C) begin
                            back_d  = bus.in_data;
                            op_d    = OP_PUSH;
                            state_d = S_ISSUE;
                        end else begin
                            fail = 1'b1;
                        end
                    end else begin
                        case (bus.in_data[2:0])
                            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                                if (count_q >= 3'd2) begin
                                    back_d  = alu_res;
                                    op_d    = OP_RED;
                                    state_d = S_ISSUE;
                                end else begin
                                    fail = 1'b1;
                                end
                            end
                            3'd5: begin
                                if (count_q >= 3'd2) begin
                                    mul_a_d = opa;
                                    mul_b_d = opb;
                                    acc_d   = 8'h00;
                                    iter_d  = '0;
                                    state_d = S_MUL;
                                end else begin
                                    fail = 1'b1;
                                end
                            end
                            3'd6: begin
                                if (count_q >= 3'd1) begin
                                    res_data_d  = opa;
                                    res_valid_d = 1'b1;
                                    op_d        = OP_POP;
                                    state_d     = S_ISSUE;
                                end else begin
                                    fail = 1'b1;
                                end
                            end
                            default: fail = 1'b1;
                        endcase
                    end
                end
                if (fail) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_MUL: begin
                acc_d   = acc_step;
                mul_a_d = mul_a_q << 1;
                mul_b_d = mul_b_q >> 1;
                iter_d  = iter_q + IW'(1);
                // The final iteration's sum goes straight to q_back so ISSUE follows without a gap.
                if (iter_q == IW'(MUL_CYCLES - 1)) begin
                    back_d  = acc_step;
                    op_d    = OP_RED;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                count_d = (op_q == OP_PUSH) ? (count_q + 3'd1) : (count_q - 3'd1);
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_ERR;
        endcase

        if (bus.q_is_err) begin
            err_d   = 1'b1;
            state_d = S_ERR;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            back_q      <= 8'h00;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            err_q       <= 1'b0;
            count_q     <= 3'd0;
            mul_a_q     <= 8'h00;
            mul_b_q     <= 8'h00;
            acc_q       <= 8'h00;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            back_q      <= back_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            count_q     <= count_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            acc_q       <= acc_d;
            iter_q      <= iter_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !err_q;
    assign bus.q_opcode  = (state_q == S_ISSUE) ? op_q : OP_NOP;
    assign bus.q_back    = back_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.err       = err_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer, with a behavioural model of the operand queue.
// Expected strobes and results are queued as commands are driven, then matched by a monitor.
module tb_calc_sequencer;
    localparam logic [7:0] C_ADD = 8'd0, C_SUB = 8'd1, C_AND = 8'd2, C_OR = 8'd3,
                           C_XOR = 8'd4, C_MUL = 8'd5, C_EMIT = 8'd6, C_ILL = 8'd7;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    calc_sequencer_if bus ();

    calc_sequencer #(.QDEPTH(5), .MUL_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand queue model; the array update is deferred so the DUT samples the pre-edge front pair.
    logic [7:0] qm [8];
    int         qn;
    logic [7:0] qt [8];
    int         qt_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qn <= 0;
        end else begin
            qt   = qm;
            qt_n = qn;
            case (bus.q_opcode)
                2'b00: if (qt_n < 8) begin qt[qt_n] = bus.q_back; qt_n++; end
                2'b10: if (qt_n >= 2) begin
                    for (int i = 0; i < 6; i++) qt[i] = qt[i+2];
                    qt[qt_n-2] = bus.q_back;
                    qt_n--;
                end
                2'b11: if (qt_n >= 1) begin
                    for (int i = 0; i < 7; i++) qt[i] = qt[i+1];
                    qt_n--;
                end
                default: ;
            endcase
            qm <= qt;
            qn <= qt_n;
        end
    end

    assign bus.q_top_conc = {(qn > 1) ? qm[1] : 8'h00, (qn > 0) ? qm[0] : 8'h00};

    // Scoreboard: strobe entries are {check_back, opcode, back}.
    logic [10:0] exp_strobe_q [$];
    logic [7:0]  exp_res_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.q_opcode !== 2'b01) begin
                logic [10:0] e;
                checks++;
                if (exp_strobe_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got op=%b back=%h, required none", bus.q_opcode, bus.q_back);
                end else begin
                    e = exp_strobe_q.pop_front();
                    if (bus.q_opcode !== e[9:8] || (e[10] && bus.q_back !== e[7:0])) begin
                        errors++;
                        $display("FAIL strobe: got op=%b back=%h, required op=%b back=%h", bus.q_opcode, bus.q_back, e[9:8], e[7:0]);
                    end else begin
                        $display("strobe op=%b back=%h", bus.q_opcode, bus.q_back);
                    end
                end
            end
            if (bus.res_valid) begin
                logic [7:0] r;
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got res_data=%h, required none", bus.res_data);
                end else begin
                    r = exp_res_q.pop_front();
                    if (bus.res_data !== r) begin
                        errors++;
                        $display("FAIL result: got res_data=%h, required %h", bus.res_data, r);
                    end else begin
                        $display("result res_data=%h", bus.res_data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.q_is_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for in_ready, then holds the command across one accept edge.
    task automatic send(input logic kind, input logic [7:0] data);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
        end
        bus.in_kind  = kind;
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic push_op(input logic [7:0] v);
        exp_strobe_q.push_back({1'b1, 2'b00, v});
        send(1'b0, v);
        step();
    endtask

    task automatic alu_op(input logic [7:0] code, input logic [7:0] expect_v);
        exp_strobe_q.push_back({1'b1, 2'b10, expect_v});
        send(1'b1, code);
        step();
    endtask

    task automatic emit_op(input logic [7:0] expect_v);
        exp_strobe_q.push_back({1'b0, 2'b11, 8'h00});
        exp_res_q.push_back(expect_v);
        send(1'b1, C_EMIT);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_kind = 1'b0; bus.in_data = 8'h00; bus.q_is_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.q_opcode !== 2'b01) begin errors++; $display("FAIL reset_opcode: got %b, required 01", bus.q_opcode); end
        checks++; if (bus.q_back !== 8'h00) begin errors++; $display("FAIL reset_back: got %h, required 00", bus.q_back); end
        checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00) begin errors++; $display("FAIL reset_res: got %b/%h, required 0/00", bus.res_valid, bus.res_data); end
        checks++; if (bus.err !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL reset_err_count: got %b/%0d, required 0/0", bus.err, bus.count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add_emit();
        logic [7:0] a = 8'h03, b = 8'h04;
        push_op(a);
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL add_count1: got %0d, required 1", bus.count); end
        push_op(b);
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL add_count2: got %0d, required 2", bus.count); end
        alu_op(C_ADD, 8'h07);
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL add_count3: got %0d, required 1", bus.count); end
        emit_op(a + b);
        checks++; if (bus.count !== 3'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL add_final: got count=%0d err=%b, required 0/0", bus.count, bus.err); end
        checks++; if (exp_strobe_q.size() != 0 || exp_res_q.size() != 0) begin errors++; $display("FAIL add_missing: got %0d strobes/%0d results pending, required 0", exp_strobe_q.size(), exp_res_q.size()); end
    endtask

    task automatic test_logic_ops();
        logic [31:0] tbl [4] = '{ {C_SUB, 8'h02, 8'h05, 8'hFD}, {C_AND, 8'hF0, 8'h3C, 8'h30},
                                  {C_OR,  8'hF0, 8'h3C, 8'hFC}, {C_XOR, 8'hF0, 8'h3C, 8'hCC} };
        for (int i = 0; i < 4; i++) begin
            push_op(tbl[i][23:16]);
            push_op(tbl[i][15:8]);
            alu_op(tbl[i][31:24], tbl[i][7:0]);
            emit_op(tbl[i][7:0]);
            checks++; if (bus.count !== 3'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL logic_%0d_state: got count=%0d err=%b, required 0/0", i, bus.count, bus.err); end
        end
        checks++; if (exp_strobe_q.size() != 0 || exp_res_q.size() != 0) begin errors++; $display("FAIL logic_missing: got %0d/%0d pending, required 0", exp_strobe_q.size(), exp_res_q.size()); end
    endtask

    task automatic test_mul();
        int low = 0;
        int edges = 0;
        push_op(8'h14);
        push_op(8'h0D);
        exp_strobe_q.push_back({1'b1, 2'b10, 8'h04});
        send(1'b1, C_MUL);
        while (edges < 40) begin
            @(negedge clk);
            if (!bus.in_ready) low++;
            step();
            edges++;
            if (bus.count !== 3'd2) break;
        end
        checks++; if (low != 9) begin errors++; $display("FAIL mul_ready_low: got %0d cycles, required 9", low); end
        checks++; if (edges != 9) begin errors++; $display("FAIL mul_update_edge: got %0d edges, required 9", edges); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL mul_count: got %0d, required 1", bus.count); end
        emit_op(8'h04);
        checks++; if (exp_strobe_q.size() != 0 || exp_res_q.size() != 0) begin errors++; $display("FAIL mul_missing: got %0d/%0d pending, required 0", exp_strobe_q.size(), exp_res_q.size()); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) push_op(8'h10 + 8'(i));
        checks++; if (bus.count !== 3'd5 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_full: got count=%0d ready=%b, required 5/1", bus.count, bus.in_ready); end
        send(1'b0, 8'h55);
        checks++; if (bus.err !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_err: got err=%b ready=%b, required 1/0", bus.err, bus.in_ready); end
        @(negedge clk);
        bus.in_kind = 1'b1; bus.in_data = C_EMIT; bus.in_valid = 1'b1;
        repeat (4) step();
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== 3'd5 || bus.err !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_hold: got count=%0d err=%b ready=%b, required 5/1/0", bus.count, bus.err, bus.in_ready); end
    endtask

    task automatic test_underflow();
        do_reset();
        push_op(8'h01);
        send(1'b1, C_ADD);
        step();
        checks++; if (bus.err !== 1'b1 || bus.count !== 3'd1) begin errors++; $display("FAIL unf_add: got err=%b count=%0d, required 1/1", bus.err, bus.count); end
        do_reset();
        send(1'b1, C_EMIT);
        step();
        checks++; if (bus.err !== 1'b1 || bus.count !== 3'd0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL unf_emit: got err=%b count=%0d rv=%b, required 1/0/0", bus.err, bus.count, bus.res_valid); end
        do_reset();
        send(1'b1, C_ILL);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_op: got err=%b, required 1", bus.err); end
        do_reset();
        push_op(8'h02);
        send(1'b1, C_MUL);
        repeat (10) step();
        checks++; if (bus.err !== 1'b1 || bus.count !== 3'd1) begin errors++; $display("FAIL unf_mul: got err=%b count=%0d, required 1/1", bus.err, bus.count); end
    endtask

    task automatic test_rst_mid_mul();
        do_reset();
        push_op(8'h02);
        push_op(8'h03);
        send(1'b1, C_MUL);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.q_opcode !== 2'b01 || bus.q_back !== 8'h00) begin errors++; $display("FAIL rstmul_q: got op=%b back=%h, required 01/00", bus.q_opcode, bus.q_back); end
        checks++; if (bus.count !== 3'd0 || bus.err !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== 8'h00) begin errors++; $display("FAIL rstmul_regs: got count=%0d err=%b rv=%b rd=%h, required 0/0/0/00", bus.count, bus.err, bus.res_valid, bus.res_data); end
        @(negedge clk);
        rst = 1'b0;
        push_op(8'h09);
        emit_op(8'h09);
        checks++; if (exp_strobe_q.size() != 0 || exp_res_q.size() != 0) begin errors++; $display("FAIL rstmul_missing: got %0d/%0d pending, required 0", exp_strobe_q.size(), exp_res_q.size()); end
    endtask

    task automatic test_q_is_err();
        do_reset();
        @(negedge clk);
        bus.q_is_err = 1'b1;
        step();
        bus.q_is_err = 1'b0;
        step();
        checks++; if (bus.err !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL q_is_err: got err=%b ready=%b, required 1/0", bus.err, bus.in_ready); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_emit();
        test_logic_ops();
        test_mul();
        test_overflow();
        test_underflow();
        test_rst_mid_mul();
        test_q_is_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
